update_scheduler: RTL and testbench

//  Arbitrates edge-weight updates from NREQ market-feed requesters, buffers them in a FIFO and

---
 rtl/hft_pkg.sv | 33 +++
 rtl/update_fifo.sv | 67 ++++++
 rtl/update_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_update_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Shared types and default sizing for the update scheduler and its update buffer.
package hft_pkg;

    localparam int unsigned HFT_NREQ       = 4;
    localparam int unsigned HFT_IDX_W      = 6;
    localparam int unsigned HFT_WEIGHT_W   = 32;
    localparam int unsigned HFT_FIFO_DEPTH = 8;
    localparam int unsigned HFT_TIMEOUT    = 4096;

    // One edge-weight update as carried from a feed requester to the container.
    typedef struct packed {
        logic        [HFT_IDX_W-1:0]    src;
        logic        [HFT_IDX_W-1:0]    dst;
        logic signed [HFT_WEIGHT_W-1:0] e;
    } edge_update_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        PULSE = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        if (cur + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return cur + 32'd1;
        end
    endfunction

endpackage

// File: rtl/update_fifo.sv
// Synchronous update buffer. Simultaneous push/pop is allowed; a push is refused
// whenever the buffer is full at the start of the cycle, and a pop never sees a
// same-cycle push (no bypass path).
module update_fifo
    import hft_pkg::*;
#(
    parameter type         entry_t = edge_update_t,
    parameter int unsigned DEPTH   = HFT_FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           push_ok_s;
    logic           pop_ok_s;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next storage and pointer values from this cycle's accepted push/pop.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers; reset flushes the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/update_scheduler.sv
// Round-robin arbitration of feed updates into a buffer, then one container run
// per update: present the edge, pulse container_reset, wait for a fresh done or
// the watchdog, and count the run.
module update_scheduler
    import hft_pkg::*;
#(
    parameter int unsigned NREQ       = HFT_NREQ,
    parameter int unsigned IDX_W      = HFT_IDX_W,
    parameter int unsigned WEIGHT_W   = HFT_WEIGHT_W,
    parameter int unsigned FIFO_DEPTH = HFT_FIFO_DEPTH,
    parameter int unsigned TIMEOUT    = HFT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*IDX_W-1:0]    req_src,
    input  logic [NREQ*IDX_W-1:0]    req_dst,
    input  logic [NREQ*WEIGHT_W-1:0] req_e,
    input  logic [IDX_W-1:0]         cfg_src,
    output logic [IDX_W-1:0]         u_src,
    output logic [IDX_W-1:0]         u_dst,
    output logic [WEIGHT_W-1:0]      u_e,
    output logic [IDX_W-1:0]         src,
    output logic                     container_reset,
    input  logic                     container_done,
    output logic                     busy,
    output logic [15:0]              run_count,
    output logic                     timeout_err
);

    localparam int unsigned    PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned    WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef struct packed {
        logic        [IDX_W-1:0]    src;
        logic        [IDX_W-1:0]    dst;
        logic signed [WEIGHT_W-1:0] e;
    } upd_t;

    logic [IDX_W-1:0]    src_arr_s [NREQ];
    logic [IDX_W-1:0]    dst_arr_s [NREQ];
    logic [WEIGHT_W-1:0] e_arr_s   [NREQ];

    logic [NREQ-1:0]  grant_s;
    logic [PTR_W-1:0] gnt_idx_s;
    logic [PTR_W-1:0] cand_s;
    logic             found_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    upd_t             push_data_s;
    upd_t             head_s;

    sched_state_t     state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    upd_t             upd_q, upd_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic             container_reset_q, container_reset_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [15:0]      run_count_q, run_count_d;
    logic             timeout_err_q, timeout_err_d;

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign src_arr_s[gi] = req_src[gi*IDX_W +: IDX_W];
        assign dst_arr_s[gi] = req_dst[gi*IDX_W +: IDX_W];
        assign e_arr_s[gi]   = req_e[gi*WEIGHT_W +: WEIGHT_W];
    end

    // Round-robin search from the pointer; nothing is granted while the buffer is full.
    always_comb begin
        grant_s     = '0;
        gnt_idx_s   = rr_ptr_q;
        cand_s      = rr_ptr_q;
        found_s     = 1'b0;
        push_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = PTR_W'((32'(rr_ptr_q) + 32'(i)) % NREQ);
            if (!found_s && !fifo_full_s && req_valid[cand_s]) begin
                found_s         = 1'b1;
                grant_s[cand_s] = 1'b1;
                gnt_idx_s       = cand_s;
                push_data_s.src = src_arr_s[cand_s];
                push_data_s.dst = dst_arr_s[cand_s];
                push_data_s.e   = e_arr_s[cand_s];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Ready is held low while reset is asserted so no requester believes it was accepted.
    assign req_ready = grant_s & {NREQ{reset_n}};
    assign push_s    = |(req_valid & req_ready);

    update_fifo #(
        .entry_t (upd_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Sequencer next state: done seen in the pulse cycle is stale and deliberately ignored.
    always_comb begin
        state_d           = state_q;
        upd_d             = upd_q;
        src_d             = src_q;
        container_reset_d = 1'b0;
        wd_d              = wd_q;
        run_count_d       = run_count_q;
        timeout_err_d     = timeout_err_q;
        pop_s             = 1'b0;
        if (push_s) begin
            rr_ptr_d = PTR_W'(rr_next(32'(gnt_idx_s), NREQ));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                pop_s             = 1'b1;
                upd_d             = head_s;
                src_d             = cfg_src;
                container_reset_d = 1'b1;
                state_d           = PULSE;
            end
            PULSE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (container_done) begin
                    run_count_d = run_count_q + 16'd1;
                    state_d     = IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_err_d = 1'b1;
                    run_count_d   = run_count_q + 16'd1;
                    state_d       = IDLE;
                end else begin
                    wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer, pointer and output registers; reset drops any in-flight update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            upd_q             <= '0;
            src_q             <= '0;
            container_reset_q <= 1'b0;
            wd_q              <= '0;
            run_count_q       <= 16'd0;
            timeout_err_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            upd_q             <= upd_d;
            src_q             <= src_d;
            container_reset_q <= container_reset_d;
            wd_q              <= wd_d;
            run_count_q       <= run_count_d;
            timeout_err_q     <= timeout_err_d;
        end
    end

    assign u_src           = upd_q.src;
    assign u_dst           = upd_q.dst;
    assign u_e             = upd_q.e;
    assign src             = src_q;
    assign container_reset = container_reset_q;
    assign run_count       = run_count_q;
    assign timeout_err     = timeout_err_q;
    assign busy            = (state_q != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_update_scheduler.sv
// Randomised bench for update_scheduler with a queue-based reference model and a
// behavioural container that asserts a sticky done a chosen latency after each pulse.
module tb_update_scheduler;

    localparam int NREQ  = 4;
    localparam int IDX_W = 6;
    localparam int WW    = 32;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic                  clk     = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*IDX_W-1:0] req_src = '0;
    logic [NREQ*IDX_W-1:0] req_dst = '0;
    logic [NREQ*WW-1:0]    req_e   = '0;
    logic [IDX_W-1:0]      cfg_src = '0;
    logic [IDX_W-1:0]      u_src, u_dst, src;
    logic [WW-1:0]         u_e;
    logic                  container_reset;
    logic                  container_done;
    logic                  busy;
    logic [15:0]           run_count;
    logic                  timeout_err;

    update_scheduler #(
        .NREQ(NREQ), .IDX_W(IDX_W), .WEIGHT_W(WW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_e(req_e),
        .cfg_src(cfg_src),
        .u_src(u_src), .u_dst(u_dst), .u_e(u_e), .src(src),
        .container_reset(container_reset), .container_done(container_done),
        .busy(busy), .run_count(run_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural container: done clears on a pulse and rises c_lat cycles later (0 = random).
    logic c_done;
    int   c_cnt;
    int   c_lat = 3;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_done <= 1'b0;
            c_cnt  <= 0;
        end else if (container_reset) begin
            c_done <= 1'b0;
            c_cnt  <= (c_lat == 0) ? int'($urandom_range(24, 1)) : c_lat;
        end else if (!c_done && c_cnt > 0) begin
            if (c_cnt == 1) c_done <= 1'b1;
            c_cnt <= c_cnt - 1;
        end
    end
    assign container_done = c_done;

    typedef struct packed {
        logic [IDX_W-1:0] s;
        logic [IDX_W-1:0] d;
        logic [WW-1:0]    e;
    } tu_t;

    // Reference model: queue of accepted updates, RR pointer, run timeline.
    tu_t              m_q[$];
    int               m_ptr, m_run, m_t0, cyc;
    logic [IDX_W-1:0] m_us, m_ud, m_src;
    logic [WW-1:0]    m_ue;
    logic [15:0]      m_cnt;
    logic             m_terr;

    logic             p_v [NREQ];
    logic [IDX_W-1:0] p_s [NREQ];
    logic [IDX_W-1:0] p_d [NREQ];
    logic [WW-1:0]    p_e [NREQ];
    int               gen_pct = 0;
    logic [NREQ-1:0]  last_rdy;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr = 0; m_run = 0; m_t0 = -10;
        m_us = '0; m_ud = '0; m_ue = '0; m_src = '0;
        m_cnt = 16'd0; m_terr = 1'b0;
    endtask

    function automatic bit any_pending();
        bit a = 1'b0;
        for (int r = 0; r < NREQ; r++) a |= p_v[r];
        return a;
    endfunction

    task automatic gen_reqs();
        for (int r = 0; r < NREQ; r++) begin
            if (!p_v[r] && $urandom_range(99, 0) < gen_pct) begin
                p_v[r] = 1'b1;
                p_s[r] = IDX_W'($urandom);
                p_d[r] = IDX_W'($urandom);
                p_e[r] = $urandom;
            end
        end
    endtask

    // One clock cycle: drive at negedge, check just after, advance the model.
    task automatic tick();
        int sz0, g;
        logic [NREQ-1:0] exp_rdy;
        tu_t it;
        gen_reqs();
        for (int r = 0; r < NREQ; r++) begin
            req_valid[r]               = p_v[r];
            req_src[r*IDX_W +: IDX_W]  = p_s[r];
            req_dst[r*IDX_W +: IDX_W]  = p_d[r];
            req_e[r*WW +: WW]          = p_e[r];
        end
        cfg_src = IDX_W'($urandom);
        #1;
        sz0 = m_q.size();
        g = -1;
        exp_rdy = '0;
        if (sz0 < DEPTH) begin
            for (int i = 0; i < NREQ; i++) begin
                if (g < 0 && p_v[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = req_ready;
        chk("req_ready", req_ready, exp_rdy);
        if (sz0 == DEPTH) chk("full_blocks", req_ready, '0);
        chk("container_reset", container_reset, (m_run != 0 && cyc == m_t0 + 1));
        chk("busy", busy, (m_run != 0 || sz0 > 0));
        chk("u_src", u_src, m_us);
        chk("u_dst", u_dst, m_ud);
        chk("u_e", u_e, m_ue);
        chk("src", src, m_src);
        chk("run_count", run_count, m_cnt);
        chk("timeout_err", timeout_err, m_terr);
        if (m_run != 0 && cyc == m_t0) begin
            it = m_q.pop_front();
            m_us = it.s; m_ud = it.d; m_ue = it.e; m_src = cfg_src;
        end else if (m_run != 0 && cyc >= m_t0 + 2) begin
            if (container_done) begin
                m_cnt++; m_run = 0;
            end else if (cyc - m_t0 - 2 == TO - 1) begin
                m_terr = 1'b1; m_cnt++; m_run = 0;
            end
        end else if (m_run == 0 && sz0 > 0) begin
            m_run = 1; m_t0 = cyc + 1;
        end
        if (g >= 0) begin
            it.s = p_s[g]; it.d = p_d[g]; it.e = p_e[g];
            m_q.push_back(it);
            m_ptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        @(negedge clk);
        if (g >= 0) p_v[g] = 1'b0;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((m_run != 0 || m_q.size() > 0 || any_pending()) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_bound", (n < limit), 1'b1);
    endtask

    // Asynchronous reset from a negedge; outputs must be cleared while reset is low.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        for (int r = 0; r < NREQ; r++) p_v[r] = 1'b0;
        req_valid = '1;
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_container_reset", container_reset, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_u_src", u_src, '0);
        chk("rst_u_dst", u_dst, '0);
        chk("rst_u_e", u_e, '0);
        chk("rst_src", src, '0);
        chk("rst_run_count", run_count, 16'd0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        req_valid = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL global_time_limit cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] one;
        cyc = 0;
        for (int r = 0; r < NREQ; r++) begin
            p_v[r] = 1'b0; p_s[r] = '0; p_d[r] = '0; p_e[r] = '0;
        end
        model_reset();
        @(negedge clk);
        do_reset();

        // Single update from requester 0: 3 -> 5, weight -120.
        c_lat = 3;
        gen_pct = 0;
        p_v[0] = 1'b1; p_s[0] = 6'd3; p_d[0] = 6'd5; p_e[0] = -32'sd120;
        drain(100);
        chk("single_run_count", run_count, 16'd1);
        chk("single_u_e", u_e, 32'hFFFF_FF88);

        // Fairness from pointer 0 with every requester valid.
        do_reset();
        c_lat = 2;
        gen_pct = 100;
        one = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("fair_order", last_rdy, one << (k % NREQ));
        end

        // Backpressure and timeouts: container never finishes, buffer fills.
        c_lat = 100000;
        for (int k = 0; k < 80; k++) tick();
        gen_pct = 0;
        drain(2000);
        chk("timeout_sticky", timeout_err, 1'b1);

        // Reset while waiting with at least three updates queued.
        gen_pct = 100;
        begin
            int n = 0;
            while (!(m_run != 0 && cyc >= m_t0 + 2 && m_q.size() >= 3) && n < 200) begin
                tick();
                n++;
            end
            chk("reach_wait_queued", (n < 200), 1'b1);
        end
        gen_pct = 0;
        do_reset();
        c_lat = 3;
        for (int k = 0; k < 20; k++) tick();

        // Random traffic with random container latency (some runs time out).
        c_lat = 0;
        gen_pct = 30;
        for (int k = 0; k < 800; k++) tick();
        gen_pct = 0;
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
